// File: rtl/l2k_cache_ctrl.sv
`timescale 1ns/1ps
// l2k_cache_ctrl: two-port round-robin front end for a hashed direct-mapped cache.
// Keeps valid/tag per entry; refills and write-through go over one memory port.
module l2k_cache_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [31:0]           req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_rvalid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [31:0]           req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_rvalid,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  c_we,
  output logic [31:0]           c_addr_in,
  output logic [DATA_WIDTH-1:0] c_data_in,
  output logic [31:0]           c_addr_out,
  input  logic [DATA_WIDTH-1:0] c_data_out,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_WRITE,
    S_RESP
  } state_t;

  // Must match the placement hash used inside the cache itself.
  function automatic logic [IDX_W-1:0] hash_idx(input logic [31:0] a);
    logic [31:0] x;
    x = a;
    x = ((x >> 16) ^ x) * 32'h045d_9f3b;
    x = ((x >> 16) ^ x) * 32'h045d_9f3b;
    x = (x >> 16) ^ x;
    return IDX_W'(x);
  endfunction

  state_t                  state_q;
  logic                    prio_q;
  logic                    port_q;
  logic                    we_q;
  logic [31:0]             addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    mem_req_q;
  logic                    mem_we_q;
  logic                    rvalid0_q;
  logic                    rvalid1_q;
  logic [DATA_WIDTH-1:0]   rdata0_q;
  logic [DATA_WIDTH-1:0]   rdata1_q;
  logic [31:0]             cin_addr_q;
  logic [DATA_WIDTH-1:0]   cin_data_q;
  logic [NUM_ENTRIES-1:0]  valid_q;
  logic [31:0]             tag_q [NUM_ENTRIES];

  logic                    gnt0;
  logic                    gnt1;
  logic [IDX_W-1:0]        idx;
  logic                    hit;
  logic                    fill_we;
  logic [DATA_WIDTH-1:0]   fill_data;

  assign idx       = hash_idx(addr_q);
  assign hit       = valid_q[idx] && (tag_q[idx] == addr_q);
  assign fill_we   = mem_ack && ((state_q == S_REFILL) || (state_q == S_WRITE));
  assign fill_data = (state_q == S_WRITE) ? wdata_q : mem_rdata;

  // Grant is a same-cycle handshake; gating with rst keeps it low while in reset.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if ((state_q == S_IDLE) && rst) begin
      if (req0_valid && req1_valid) begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      prio_q     <= 1'b0;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      cin_addr_q <= '0;
      cin_data_q <= '0;
      valid_q    <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt0 || gnt1) begin
            port_q  <= gnt1;
            we_q    <= gnt1 ? req1_we    : req0_we;
            addr_q  <= gnt1 ? req1_addr  : req0_addr;
            wdata_q <= gnt1 ? req1_wdata : req0_wdata;
            prio_q  <= gnt0;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (we_q) begin
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
            state_q   <= S_WRITE;
          end else if (hit) begin
            if (port_q) begin
              rdata1_q  <= c_data_out;
              rvalid1_q <= 1'b1;
            end else begin
              rdata0_q  <= c_data_out;
              rvalid0_q <= 1'b1;
            end
            state_q <= S_RESP;
          end else begin
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
            state_q   <= S_REFILL;
          end
        end
        S_REFILL, S_WRITE: begin
          if (mem_ack) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            valid_q[idx] <= 1'b1;
            cin_addr_q   <= addr_q;
            cin_data_q   <= fill_data;
            if (port_q) begin
              rdata1_q  <= fill_data;
              rvalid1_q <= 1'b1;
            end else begin
              rdata0_q  <= fill_data;
              rvalid0_q <= 1'b1;
            end
            state_q <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: the tag array carries no reset; valid_q alone decides whether a tag means anything.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx] <= addr_q;
    end
  end

  // Cache write port shows live fill data on the write cycle and holds it afterwards.
  assign c_we        = fill_we;
  assign c_addr_in   = fill_we ? addr_q    : cin_addr_q;
  assign c_data_in   = fill_we ? fill_data : cin_data_q;
  assign c_addr_out  = addr_q;

  assign req0_ready  = gnt0;
  assign req1_ready  = gnt1;
  assign req0_rvalid = rvalid0_q;
  assign req1_rvalid = rvalid1_q;
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_l2k_cache_ctrl.sv
`timescale 1ns/1ps
// tb_l2k_cache_ctrl: random and directed traffic against a queue-based reference model,
// with a behavioural cache array and memory responder around the controller.
module tb_l2k_cache_ctrl;

  localparam int NE = 512;

  typedef struct {
    bit          v;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } pend_t;

  typedef struct {
    int          port;
    bit          we;
    bit          hit;
    logic [31:0] addr;
    logic [31:0] data;
    int          gcyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_we, req0_ready, req0_rvalid;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_we, req1_ready, req1_rvalid;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic        c_we;
  logic [31:0] c_addr_in, c_data_in, c_addr_out, c_data_out;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  l2k_cache_ctrl #(.DATA_WIDTH(32), .NUM_ENTRIES(NE)) dut (
    .clk(clk), .rst(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .c_we(c_we), .c_addr_in(c_addr_in), .c_data_in(c_data_in),
    .c_addr_out(c_addr_out), .c_data_out(c_data_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  pend_t       pend [2];
  exp_t        exp_q [$];
  int          grant_log [$];
  bit          busy_m = 0;
  int          ptr_m = 0;
  logic [31:0] ref_tag [int];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] cache_mem [NE];
  int          txn_cnt = 0, wtxn_cnt = 0, cwe_cnt = 0, last_ack = 0;
  int          refills_total = 0, writes_total = 0;
  bit          hold_ack = 0;
  int          delay_cfg = -1;

  function automatic int tb_idx(input logic [31:0] a);
    logic [31:0] x;
    x = a;
    x = ((x >> 16) ^ x) * 32'h045d_9f3b;
    x = ((x >> 16) ^ x) * 32'h045d_9f3b;
    x = (x >> 16) ^ x;
    return int'(x & (NE - 1));
  endfunction

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'h5bd1_e995;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural cache array: written on c_we, read combinationally by index.
  always @(posedge clk) if (c_we) cache_mem[tb_idx(c_addr_in)] <= c_data_in;
  assign c_data_out = cache_mem[tb_idx(c_addr_out)];

  // Memory responder with configurable or random latency and stray acks while idle.
  initial begin : responder
    bit r_active;
    int r_dly;
    r_active  = 0;
    r_dly     = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = $urandom();
      if (rst_n && mem_req && !hold_ack) begin
        if (!r_active) begin
          r_active = 1;
          r_dly    = (delay_cfg >= 0) ? delay_cfg : int'($urandom_range(0, 4));
        end
        if (r_dly == 0) begin
          mem_ack = 1'b1;
          if (mem_we) dev_mem[mem_addr] = mem_wdata;
          else mem_rdata = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_val(mem_addr);
          r_active = 0;
        end else begin
          r_dly--;
        end
      end else begin
        if (!mem_req) r_active = 0;
        if (rst_n && !mem_req && ($urandom_range(0, 5) == 0)) mem_ack = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a completion appears.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (mem_req && mem_ack) begin
          txn_cnt++;
          if (mem_we) wtxn_cnt++;
          last_ack = cyc;
          if (exp_q.size() > 0) begin
            check("mem_addr", mem_addr, exp_q[0].addr);
            if (mem_we) check("mem_wdata", mem_wdata, exp_q[0].data);
          end
        end
        if (c_we) begin
          cwe_cnt++;
          if (exp_q.size() > 0) begin
            check("c_addr_in", c_addr_in, exp_q[0].addr);
            check("c_data_in", c_data_in, exp_q[0].data);
          end
        end
        if (req0_rvalid || req1_rvalid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rvalid: got rvalid %b%b expected none", req1_rvalid, req0_rvalid);
          end else begin
            e = exp_q.pop_front();
            check("rvalid_port", 32'({req1_rvalid, req0_rvalid}), (e.port == 1) ? 32'd2 : 32'd1);
            check("rdata", (e.port == 1) ? req1_rdata : req0_rdata, e.data);
            check("mem_txn", 32'(txn_cnt), e.hit ? 32'd0 : 32'd1);
            check("mem_writes", 32'(wtxn_cnt), 32'(e.we));
            check("c_we_count", 32'(cwe_cnt), e.hit ? 32'd0 : 32'd1);
            if (e.hit) check("hit_latency", 32'(cyc - e.gcyc), 32'd2);
            else       check("ack_latency", 32'(cyc - last_ack), 32'd1);
            if (!e.hit && !e.we) refills_total++;
            if (e.we) writes_total++;
          end
          txn_cnt  = 0;
          wtxn_cnt = 0;
          cwe_cnt  = 0;
          busy_m   = 0;
        end
      end
    end
  end

  task automatic grant();
    exp_t e;
    int   p_exp;
    int   ix;
    check("ready_while_busy", 32'(busy_m), 32'd0);
    p_exp = (pend[0].v && pend[1].v) ? ptr_m : (pend[1].v ? 1 : 0);
    check("grant_port", 32'({req1_ready, req0_ready}), (p_exp == 1) ? 32'd2 : 32'd1);
    ptr_m  = 1 - p_exp;
    ix     = tb_idx(pend[p_exp].addr);
    e.port = p_exp;
    e.we   = pend[p_exp].we;
    e.addr = pend[p_exp].addr;
    e.hit  = !e.we && ref_tag.exists(ix) && (ref_tag[ix] == e.addr);
    e.data = e.we ? pend[p_exp].data : ref_read(e.addr);
    e.gcyc = cyc;
    if (e.we) ref_mem[e.addr] = e.data;
    if (!e.hit) ref_tag[ix] = e.addr;
    exp_q.push_back(e);
    grant_log.push_back(p_exp);
    pend[p_exp].v = 0;
    busy_m = 1;
  endtask

  task automatic cycle();
    @(negedge clk);
    req0_valid = pend[0].v; req0_we = pend[0].we; req0_addr = pend[0].addr; req0_wdata = pend[0].data;
    req1_valid = pend[1].v; req1_we = pend[1].we; req1_addr = pend[1].addr; req1_wdata = pend[1].data;
    #1;
    if (req0_ready || req1_ready) grant();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy_m || pend[0].v || pend[1].v) && (n < budget)) begin
      cycle();
      n++;
    end
    check("idle_within_budget", 32'({busy_m, pend[0].v, pend[1].v}), 32'd0);
  endtask

  task automatic issue(input int p, input bit we, input logic [31:0] addr, input logic [31:0] data);
    pend[p] = '{v: 1'b1, we: we, addr: addr, data: data};
    wait_idle(200);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_ctrl_outs", 32'({mem_req, mem_we, c_we, req1_rvalid, req0_rvalid}), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rdata", req0_rdata | req1_rdata, 32'd0);
    check("rst_c_in", c_addr_in | c_data_in, 32'd0);
    exp_q.delete();
    ref_tag.delete();
    busy_m = 0;
    ptr_m  = 0;
    pend[0].v = 0;
    pend[1].v = 0;
    txn_cnt = 0; wtxn_cnt = 0; cwe_cnt = 0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rst_no_ready", 32'({req1_ready, req0_ready}), 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin : stimulus
    logic [31:0] a_addr, b_addr;
    logic [31:0] pool [8];
    int          base, n, r0, w0;
    rst_n = 1'b0;
    req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
    pend[0] = '{v: 1'b0, we: 1'b0, addr: '0, data: '0};
    pend[1] = pend[0];
    @(negedge clk);
    do_reset();

    // Cold read miss, then the same address hits.
    dev_mem[32'h1000] = 32'hdead_beef;
    ref_mem[32'h1000] = 32'hdead_beef;
    delay_cfg = 3;
    r0 = refills_total;
    issue(0, 1'b0, 32'h1000, '0);
    check("cold_read_refills", 32'(refills_total - r0), 32'd1);
    check("cold_read_rdata", req0_rdata, 32'hdead_beef);
    r0 = refills_total;
    issue(0, 1'b0, 32'h1000, '0);
    check("hit_read_refills", 32'(refills_total - r0), 32'd0);
    delay_cfg = -1;

    // Write-through with allocate, then a hitting read.
    w0 = writes_total;
    r0 = refills_total;
    issue(1, 1'b1, 32'h2000, 32'h1234_5678);
    issue(1, 1'b0, 32'h2000, '0);
    check("write_mem_writes", 32'(writes_total - w0), 32'd1);
    check("write_then_read_refills", 32'(refills_total - r0), 32'd0);
    check("write_then_read_rdata", req1_rdata, 32'h1234_5678);

    // Two addresses sharing an index evict each other.
    a_addr = 32'h3000;
    b_addr = a_addr + 4;
    for (int k = 0; k < 100000 && (tb_idx(b_addr) != tb_idx(a_addr)); k++) b_addr += 4;
    check("collision_found", 32'(tb_idx(b_addr)), 32'(tb_idx(a_addr)));
    r0 = refills_total;
    issue(0, 1'b0, a_addr, '0);
    issue(0, 1'b0, b_addr, '0);
    issue(0, 1'b0, a_addr, '0);
    check("collision_refills", 32'(refills_total - r0), 32'd3);

    // Round-robin with both ports requesting three times from a fresh pointer.
    do_reset();
    base = grant_log.size();
    pend[0] = '{v: 1'b1, we: 1'b0, addr: 32'h4000, data: '0};
    pend[1] = '{v: 1'b1, we: 1'b0, addr: 32'h5000, data: '0};
    n = 0;
    while ((grant_log.size() < base + 3) && (n < 300)) begin
      cycle();
      n++;
      if ((grant_log.size() == base + 1) && !pend[0].v)
        pend[0] = '{v: 1'b1, we: 1'b0, addr: 32'h4100, data: '0};
      if ((grant_log.size() == base + 2) && !pend[1].v)
        pend[1] = '{v: 1'b1, we: 1'b0, addr: 32'h5100, data: '0};
    end
    wait_idle(200);
    for (int k = 0; k < 3; k++)
      check($sformatf("rr_grant%0d", k),
            (grant_log.size() > base + k) ? 32'(grant_log[base + k]) : 32'hffff,
            (k == 1) ? 32'd1 : 32'd0);

    // Reset in the middle of a refill aborts it cleanly.
    hold_ack = 1;
    pend[0] = '{v: 1'b1, we: 1'b0, addr: 32'h7000, data: '0};
    n = 0;
    while (!mem_req && (n < 50)) begin
      cycle();
      n++;
    end
    check("refill_entered", 32'(mem_req), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #2;
    do_reset();
    hold_ack = 0;
    r0 = refills_total;
    issue(0, 1'b0, 32'h7000, '0);
    check("post_abort_refills", 32'(refills_total - r0), 32'd1);

    // Randomised mix of ports, reads, writes, hits and collisions.
    pool[0] = 32'h1000; pool[1] = 32'h2000; pool[2] = a_addr; pool[3] = b_addr;
    pool[4] = 32'h4000; pool[5] = 32'h7000;
    pool[6] = $urandom() & 32'hffff_fffc; pool[7] = $urandom() & 32'hffff_fffc;
    for (int i = 0; i < 150; i++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      for (int p = 0; p < 2; p++)
        if ((mode == p) || (mode == 2))
          pend[p] = '{v: 1'b1, we: ($urandom_range(0, 2) == 0), addr: pool[$urandom_range(0, 7)],
                      data: $urandom()};
      wait_idle(200);
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/l2k_cache_ctrl.md
L2K_CACHE_CTRL -- requirements
Module: l2k_cache_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of cached data word.
REQ-002 SHALL have parameter NUM_ENTRIES, default 512, power of two, entry count of the controlled hashed cache.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-005 SHALL have ports reqN_valid in 1, reqN_we in 1, reqN_addr in 32, reqN_wdata in DATA_WIDTH, for N = 0 (fetch) and 1 (data).
REQ-006 SHALL have ports reqN_ready out 1 (grant pulse), reqN_rvalid out 1 (completion pulse), reqN_rdata out DATA_WIDTH, for N = 0, 1.
REQ-007 SHALL have cache-side ports c_we out 1, c_addr_in out 32, c_data_in out DATA_WIDTH, c_addr_out out 32, c_data_out in DATA_WIDTH.
REQ-008 SHALL have memory ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out DATA_WIDTH, mem_ack in 1, mem_rdata in DATA_WIDTH.

Function
REQ-009 SHALL compute index = H(addr) & (NUM_ENTRIES-1), H: x=((x>>16)^x)*0x45d9f3b, repeated once, then (x>>16)^x, all mod 2^32, matching the cache's internal placement.
REQ-010 SHALL hold per-entry valid bit and 32-bit full-address tag, indexed by index; hit = valid[idx] && tag[idx]==addr.
REQ-011 SHALL implement FSM states IDLE, LOOKUP, REFILL, WRITE, RESP.
REQ-012 IDLE: if any reqN_valid, grant one; reqN_ready=1 that cycle only; latch addr/we/wdata/port; next LOOKUP.
REQ-013 Arbitration SHALL be round-robin: both valid -> grant port indicated by priority pointer; pointer then points to the other port; single requester always granted.
REQ-014 LOOKUP: c_addr_out = latched addr; read hit -> RESP with rdata = c_data_out; read miss -> REFILL; write (hit or miss) -> WRITE.
REQ-015 REFILL: mem_req=1, mem_we=0, mem_addr=latched addr, held stable until mem_ack; on mem_ack cycle: c_we=1, c_addr_in=addr, c_data_in=mem_rdata, valid/tag set, rdata=mem_rdata, next RESP.
REQ-016 WRITE: mem_req=1, mem_we=1, mem_wdata=latched wdata until mem_ack; on mem_ack: c_we=1 with addr/wdata, valid/tag set (write-through, write-allocate), rdata=wdata, next RESP.
REQ-017 RESP: rvalid=1 for granted port only, exactly one cycle, rdata held until next completion; next IDLE.
REQ-018 c_addr_in/c_data_in SHALL be registers updated only on c_we cycles, keeping the cache's addr_in==addr_out bypass coherent with stored data.
REQ-019 c_we SHALL be 1 only on the mem_ack cycle of REFILL/WRITE; mem_req SHALL be 0 outside REFILL/WRITE.
REQ-020 Latency: read hit rvalid 2 cycles after ready; miss/write rvalid 1 cycle after mem_ack.
REQ-021 One outstanding request; reqN_valid while busy SHALL be ignored (no ready) until IDLE.
REQ-022 mem_ack outside REFILL/WRITE SHALL be ignored.
REQ-023 Index collision on refill/write SHALL overwrite tag; previous address then misses.

Reset
REQ-024 rst=0 SHALL asynchronously force IDLE, clear all valid bits, priority pointer to port 0, all outputs 0.
REQ-025 Reset mid-REFILL/WRITE SHALL drop mem_req immediately; aborted request gets no rvalid, no cache write.
REQ-026 After rst release, first request SHALL be granted no earlier than the first rising edge.

Verification
REQ-027 Post-reset read req0 addr 0x1000, mem_rdata 0xDEADBEEF ack after 3 cycles -> one mem_req read, c_we pulse, req0_rvalid with 0xDEADBEEF.
REQ-028 Repeat read 0x1000 -> no mem_req, req0_rvalid 2 cycles after ready, rdata 0xDEADBEEF.
REQ-029 req0 and req1 valid together three times -> grants 0,1,0; each rvalid only on its port.
REQ-030 req1 write 0x2000 data 0x12345678 then read 0x2000 -> mem_we=1 once, read hits, returns 0x12345678.
REQ-031 Two addresses with equal index: read A, read B, read A -> three refills (A evicted by B).
REQ-032 rst low two cycles after REFILL entry -> mem_req 0 at once, no rvalid, next read of same addr misses.
